multicycle_control: RTL and testbench

Multi-cycle main control unit for the 4-bit-opcode core. Replaces the single-cycle combinational decoder with a state machine that sequences fetch, decode, execute, memory and writeback over several cycles against a shared instruction/data memory with a ready handshake. It sits between the instruction register and the datapath: it samples the opcode and drives all mux selects, ALU operation and write enables. Every output is fully defined in every state; no outputs are ever driven to X.

---
 rtl/control_pkg.sv | 22 ++
 rtl/multicycle_control_if.sv | 19 +
 rtl/control_decode.sv | 37 +++
 rtl/multicycle_control.sv | 100 ++++++++++
 tb/tb_multicycle_control.sv | 169 ++++++++++++++++
 5 files changed

// File: rtl/control_pkg.sv
// control_pkg: shared FSM states, opcode encodings and ALU op constants for the multicycle controller.
package control_pkg;
  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DECODE, S_EXECUTE, S_MEM, S_WRITEBACK
`ifdef CONTROL_TIMEOUT_EN
    , S_FAULT
`endif
  } state_t;
  typedef enum logic [2:0] {C_ALU, C_LW, C_SW, C_NOP, C_ILL} op_class_t;
  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_ADDI = 4'b0001;
  localparam logic [3:0] OP_SUB  = 4'b0010;
  localparam logic [3:0] OP_AND  = 4'b0011;
  localparam logic [3:0] OP_OR   = 4'b0100;
  localparam logic [3:0] OP_LW   = 4'b1000;
  localparam logic [3:0] OP_SW   = 4'b1001;
  localparam logic [3:0] OP_NOP  = 4'b1111;
  localparam logic [4:0] ALU_AND = 5'b00000;
  localparam logic [4:0] ALU_OR  = 5'b00001;
  localparam logic [4:0] ALU_ADD = 5'b00010;
  localparam logic [4:0] ALU_SUB = 5'b01110;
endpackage

// File: rtl/multicycle_control_if.sv
// multicycle_control_if: opcode/memory-ready inputs and datapath control outputs of the controller.
interface multicycle_control_if #(parameter int OPCODE_W = 4, parameter int ALUOP_W = 5);
  logic [OPCODE_W-1:0] opcode;
  logic mem_ready;
  logic ctl_pcwrite, ctl_irwrite, ctl_iord, ctl_alusrc;
  logic [ALUOP_W-1:0] ctl_aluop;
  logic ctl_regdst, ctl_memtoreg, ctl_memread, ctl_memwrite, ctl_regwrite;
  logic ctl_illegal, ctl_fault;
  modport master (
    input  opcode, mem_ready,
    output ctl_pcwrite, ctl_irwrite, ctl_iord, ctl_alusrc, ctl_aluop, ctl_regdst,
           ctl_memtoreg, ctl_memread, ctl_memwrite, ctl_regwrite, ctl_illegal, ctl_fault
  );
  modport slave (
    output opcode, mem_ready,
    input  ctl_pcwrite, ctl_irwrite, ctl_iord, ctl_alusrc, ctl_aluop, ctl_regdst,
           ctl_memtoreg, ctl_memread, ctl_memwrite, ctl_regwrite, ctl_illegal, ctl_fault
  );
endinterface

// File: rtl/control_decode.sv
// control_decode: combinational opcode classification and per-opcode ALU/writeback selects.
module control_decode import control_pkg::*; #(
  parameter int OPCODE_W = 4,
  parameter int ALUOP_W  = 5
) (
  input  logic [OPCODE_W-1:0] op,
  output op_class_t           cls,
  output logic                alusrc,
  output logic [ALUOP_W-1:0]  aluop,
  output logic                regdst,
  output logic                memtoreg
);
  logic hi_bad;
  logic [4:0] aop;
  // any set bit above the 4-bit opcode field makes the instruction illegal
  assign hi_bad = (op >> 4) != '0;
  assign aluop = ALUOP_W'(aop);
  always_comb begin
    cls = C_ILL;
    alusrc = 1'b0;
    aop = ALU_AND;
    regdst = 1'b0;
    memtoreg = 1'b0;
    if (!hi_bad)
      case (op[3:0])
        OP_ADD:  begin cls = C_ALU; aop = ALU_ADD; regdst = 1'b1; end
        OP_ADDI: begin cls = C_ALU; aop = ALU_ADD; alusrc = 1'b1; end
        OP_SUB:  begin cls = C_ALU; aop = ALU_SUB; regdst = 1'b1; end
        OP_AND:  begin cls = C_ALU; aop = ALU_AND; regdst = 1'b1; end
        OP_OR:   begin cls = C_ALU; aop = ALU_OR;  regdst = 1'b1; end
        OP_LW:   begin cls = C_LW;  aop = ALU_ADD; alusrc = 1'b1; memtoreg = 1'b1; end
        OP_SW:   begin cls = C_SW;  aop = ALU_ADD; alusrc = 1'b1; end
        OP_NOP:  cls = C_NOP;
        default: cls = C_ILL;
      endcase
  end
endmodule

// File: rtl/multicycle_control.sv
// multicycle_control: fetch/decode/execute/mem/writeback sequencer; CONTROL_TIMEOUT_EN adds a memory-wait timeout FAULT state.
module multicycle_control import control_pkg::*; #(
  parameter int OPCODE_W = 4,
  parameter int ALUOP_W  = 5
`ifdef CONTROL_TIMEOUT_EN
  , parameter int MEM_TIMEOUT = 15
`endif
) (
  input logic clk,
  input logic rst,
  multicycle_control_if.master bus
);
  state_t state_q, state_d;
  logic [OPCODE_W-1:0] op_q, op_d;
  op_class_t cls;
  logic alusrc, regdst, memtoreg;
  logic [ALUOP_W-1:0] aluop;
  // decoding the live opcode in DECODE lets the illegal pulse and branch use it before it is latched
  assign op_d = state_q == S_DECODE ? bus.opcode : op_q;
  control_decode #(.OPCODE_W(OPCODE_W), .ALUOP_W(ALUOP_W)) u_decode (
    .op(op_d), .cls(cls), .alusrc(alusrc), .aluop(aluop), .regdst(regdst), .memtoreg(memtoreg)
  );
`ifdef CONTROL_TIMEOUT_EN
  localparam int CNT_W = $clog2(MEM_TIMEOUT + 1);
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic wait_st;
  assign wait_st = (state_q == S_FETCH || state_q == S_MEM) && !bus.mem_ready;
`endif
  always_comb begin
    state_d = state_q;
    bus.ctl_pcwrite = 1'b0;
    bus.ctl_irwrite = 1'b0;
    bus.ctl_iord = 1'b0;
    bus.ctl_alusrc = 1'b0;
    bus.ctl_aluop = '0;
    bus.ctl_regdst = 1'b0;
    bus.ctl_memtoreg = 1'b0;
    bus.ctl_memread = 1'b0;
    bus.ctl_memwrite = 1'b0;
    bus.ctl_regwrite = 1'b0;
    bus.ctl_illegal = 1'b0;
    bus.ctl_fault = 1'b0;
    case (state_q)
      S_IDLE: state_d = S_FETCH;
      S_FETCH: begin
        bus.ctl_memread = 1'b1;
        bus.ctl_pcwrite = bus.mem_ready;
        bus.ctl_irwrite = bus.mem_ready;
        state_d = bus.mem_ready ? S_DECODE : S_FETCH;
      end
      S_DECODE: begin
        bus.ctl_illegal = cls == C_ILL;
        state_d = (cls == C_NOP || cls == C_ILL) ? S_FETCH : S_EXECUTE;
      end
      S_EXECUTE: begin
        bus.ctl_alusrc = alusrc;
        bus.ctl_aluop = aluop;
        state_d = (cls == C_LW || cls == C_SW) ? S_MEM : S_WRITEBACK;
      end
      S_MEM: begin
        bus.ctl_iord = 1'b1;
        bus.ctl_alusrc = 1'b1;
        bus.ctl_aluop = ALUOP_W'(ALU_ADD);
        bus.ctl_memread = cls == C_LW;
        bus.ctl_memwrite = cls == C_SW;
        state_d = !bus.mem_ready ? S_MEM : cls == C_LW ? S_WRITEBACK : S_FETCH;
      end
      S_WRITEBACK: begin
        bus.ctl_regwrite = 1'b1;
        bus.ctl_regdst = regdst;
        bus.ctl_memtoreg = memtoreg;
        bus.ctl_alusrc = alusrc;
        bus.ctl_aluop = aluop;
        state_d = S_FETCH;
      end
`ifdef CONTROL_TIMEOUT_EN
      S_FAULT: bus.ctl_fault = 1'b1;
`endif
      default: state_d = S_IDLE;
    endcase
`ifdef CONTROL_TIMEOUT_EN
    cnt_d = wait_st ? cnt_q + 1'b1 : '0;
    if (wait_st && cnt_q == CNT_W'(MEM_TIMEOUT)) state_d = S_FAULT;
`endif
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q <= S_IDLE;
      op_q <= '0;
`ifdef CONTROL_TIMEOUT_EN
      cnt_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      op_q <= op_d;
`ifdef CONTROL_TIMEOUT_EN
      cnt_q <= cnt_d;
`endif
    end
endmodule

// File: tb/tb_multicycle_control.sv
// tb_multicycle_control: randomized instruction stream scored cycle-by-cycle against an instruction-level model.
module tb_multicycle_control;
  typedef struct packed {
    logic pcwrite, irwrite, iord, alusrc;
    logic [4:0] aluop;
    logic regdst, memtoreg, memread, memwrite, regwrite, illegal, fault;
  } outs_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int tests = 0;
  int fails = 0;
  int ncyc = 0;
  outs_t act, exp_e;
  outs_t exp_q[$];
  string name_q[$];
  string nm_e;
  logic [3:0] legal_ops [8] = '{4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h8, 4'h9, 4'hF};
  always #5 clk = ~clk;
  multicycle_control_if #(.OPCODE_W(4), .ALUOP_W(5)) bus ();
  multicycle_control #(.OPCODE_W(4), .ALUOP_W(5)) dut (.clk(clk), .rst(rst), .bus(bus));
  assign act = {bus.ctl_pcwrite, bus.ctl_irwrite, bus.ctl_iord, bus.ctl_alusrc, bus.ctl_aluop,
                bus.ctl_regdst, bus.ctl_memtoreg, bus.ctl_memread, bus.ctl_memwrite,
                bus.ctl_regwrite, bus.ctl_illegal, bus.ctl_fault};
  task automatic check(input string nm, input outs_t a, input outs_t e);
    tests++;
    if (a !== e) begin
      fails++;
      $display("FAIL %s: got %05h expected %05h", nm, a, e);
    end
  endtask
  initial forever begin
    @(negedge clk);
    if (exp_q.size() != 0) begin
      exp_e = exp_q.pop_front();
      nm_e = name_q.pop_front();
      check(nm_e, act, exp_e);
    end
  end
  function automatic logic [3:0] rnd4();
    return 4'($urandom_range(0, 15));
  endfunction
  function automatic logic rnd1();
    return 1'($urandom_range(0, 1));
  endfunction
  task automatic step(input logic rdy, input logic [3:0] op, input outs_t e);
    bus.mem_ready = rdy;
    bus.opcode = op;
    exp_q.push_back(e);
    name_q.push_back($sformatf("cyc%0d", ncyc));
    ncyc++;
    @(posedge clk);
    #1;
  endtask
  // one instruction from its FETCH to the cycle before the next FETCH, with fw/mw memory stalls
  task automatic run_instr(input logic [3:0] op, input int fw, input int mw);
    outs_t e;
    logic legal, as, rd, mtr;
    logic [4:0] ao;
    legal = 1'b1; as = 1'b0; rd = 1'b0; mtr = 1'b0; ao = 5'b00000;
    case (op)
      4'h0: begin ao = 5'b00010; rd = 1'b1; end
      4'h1: begin ao = 5'b00010; as = 1'b1; end
      4'h2: begin ao = 5'b01110; rd = 1'b1; end
      4'h3: begin ao = 5'b00000; rd = 1'b1; end
      4'h4: begin ao = 5'b00001; rd = 1'b1; end
      4'h8: begin ao = 5'b00010; as = 1'b1; mtr = 1'b1; end
      4'h9: begin ao = 5'b00010; as = 1'b1; end
      4'hF: ;
      default: legal = 1'b0;
    endcase
    for (int i = 0; i < fw; i++) begin
      e = '0; e.memread = 1'b1;
      step(1'b0, rnd4(), e);
    end
    e = '0; e.memread = 1'b1; e.pcwrite = 1'b1; e.irwrite = 1'b1;
    step(1'b1, rnd4(), e);
    e = '0; e.illegal = !legal;
    step(rnd1(), op, e);
    if (!legal || op == 4'hF) return;
    e = '0; e.alusrc = as; e.aluop = ao;
    step(rnd1(), rnd4(), e);
    if (op == 4'h8 || op == 4'h9)
      for (int i = 0; i <= mw; i++) begin
        e = '0; e.iord = 1'b1; e.alusrc = 1'b1; e.aluop = 5'b00010;
        e.memread = op == 4'h8; e.memwrite = op == 4'h9;
        step(i == mw, rnd4(), e);
      end
    if (op != 4'h9) begin
      e = '0; e.regwrite = 1'b1; e.regdst = rd; e.memtoreg = mtr; e.alusrc = as; e.aluop = ao;
      step(rnd1(), rnd4(), e);
    end
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end
  initial begin
    outs_t z, e;
    logic [3:0] op;
    z = '0;
    bus.mem_ready = 1'b1;
    bus.opcode = 4'h0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_state", act, z);
    rst = 1'b0;
    step(1'b1, rnd4(), z);
    run_instr(4'h0, 0, 0);
    run_instr(4'h8, 0, 3);
    run_instr(4'h9, 1, 2);
    run_instr(4'h5, 0, 0);
    run_instr(4'hF, 2, 0);
    run_instr(4'h2, 0, 0);
    // reset while SW is waiting in MEM
    step(1'b1, rnd4(), '{pcwrite: 1'b1, irwrite: 1'b1, memread: 1'b1, default: '0});
    step(1'b0, 4'h9, z);
    step(1'b1, rnd4(), '{alusrc: 1'b1, aluop: 5'b00010, default: '0});
    step(1'b0, rnd4(), '{iord: 1'b1, alusrc: 1'b1, aluop: 5'b00010, memwrite: 1'b1, default: '0});
    bus.mem_ready = 1'b0;
    #2;
    check("sw_mem_pre_rst", act, '{iord: 1'b1, alusrc: 1'b1, aluop: 5'b00010, memwrite: 1'b1, default: '0});
    rst = 1'b1;
    #1;
    check("rst_async_drop", act, z);
    bus.mem_ready = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1;
    check("rst_hold", act, z);
    rst = 1'b0;
    step(1'b1, rnd4(), z);
    e = '0; e.memread = 1'b1;
    step(1'b0, rnd4(), e);
    for (int n = 0; n < 60; n++) begin
      op = ($urandom_range(0, 3) != 0) ? legal_ops[$urandom_range(0, 7)] : rnd4();
      run_instr(op, $urandom_range(0, 2), $urandom_range(0, 2));
    end
`ifdef CONTROL_TIMEOUT_EN
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    step(1'b0, rnd4(), z);
    e = '0; e.memread = 1'b1;
    for (int i = 0; i < 16; i++) step(1'b0, rnd4(), e);
    e = '0; e.fault = 1'b1;
    for (int i = 0; i < 4; i++) step(rnd1(), rnd4(), e);
    rst = 1'b1;
    #1;
    check("fault_cleared", act, z);
    @(posedge clk);
    #1;
    rst = 1'b0;
    step(1'b0, rnd4(), z);
    e = '0; e.memread = 1'b1;
    for (int i = 0; i < 15; i++) step(1'b0, rnd4(), e);
    run_instr(4'h1, 0, 0);
    run_instr(4'h8, 0, 15);
`endif
    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL queue_drain: got %0d pending expected 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
